// File: rtl/dmem_if.sv
// -----------------------------------------------------------------------------
// dmem_if -- request/response bundle between a load/store requester and the
// dmem_responder data memory.
//
// Request channel  (master -> slave): req_valid, req_we, req_funct3, req_addr,
//                                     req_wdata, req_tid
//                  (slave -> master): req_ready
// Response channel (slave -> master): rsp_valid, rsp_rdata, rsp_tid, rsp_err
//                  (master -> slave): rsp_ready
//
// Both channels use valid/ready: a transfer happens on a rising clock edge
// where valid and ready are both high.
// -----------------------------------------------------------------------------
interface dmem_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int BITS_THREADS  = 3
);

  // Request channel
  logic                     req_valid;
  logic                     req_ready;
  logic                     req_we;
  logic [2:0]               req_funct3;
  logic [ADDRESS_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0]    req_wdata;
  logic [BITS_THREADS-1:0]  req_tid;

  // Response channel
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [DATA_WIDTH-1:0]    rsp_rdata;
  logic [BITS_THREADS-1:0]  rsp_tid;
  logic                     rsp_err;

  // Requester side (core / load-store unit)
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, req_tid,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_tid, rsp_err
  );

  // Responder side (data memory)
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_tid,
    input  rsp_ready,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_tid, rsp_err
  );

endinterface : dmem_if

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder -- multi-threaded RV32I data memory with an in-order response
// queue.
//
// Every accepted request (load or store) produces exactly one response, in
// acceptance order. A request is decoded against the storage contents in the
// cycle it is accepted; its response enters a 2-entry FIFO at that edge, so
// with an empty FIFO the response is presented the cycle after acceptance.
//
// Ports
//   clk   in   sole clock, rising edge
//   rst   in   asynchronous, active-low reset (clears the response FIFO only;
//              storage keeps its contents)
//   bus   dmem_if.slave
//     req_valid/req_ready   request handshake; req_ready = (count < 2)
//     req_we                1 = store, 0 = load
//     req_funct3            RV32I width/sign code (LB/LH/LW/LBU/LHU, SB/SH/SW)
//     req_addr              byte address; wraps modulo DEPTH_WORDS*4
//     req_wdata             store data, low bytes used
//     req_tid               issuing hardware thread
//     rsp_valid/rsp_ready   response handshake
//     rsp_rdata             load result (0 for stores and rejected requests)
//     rsp_tid               thread the response belongs to
//     rsp_err               request was rejected (misaligned / illegal funct3)
// -----------------------------------------------------------------------------
module dmem_responder #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int NUM_THREADS   = 8,
  parameter int BITS_THREADS  = $clog2(NUM_THREADS),
  parameter int DEPTH_WORDS   = 1024
) (
  input  logic  clk,
  input  logic  rst,
  dmem_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  // RV32I funct3 width/sign codes
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [DATA_WIDTH-1:0] BYTE_MASK = DATA_WIDTH'(8'hFF);
  localparam logic [DATA_WIDTH-1:0] HALF_MASK = DATA_WIDTH'(16'hFFFF);

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic       req_ready_w;
  logic       rsp_valid_w;
  logic       push;
  logic       pop;
  logic [1:0] count_q, count_d;
  logic       head_q, head_d;
  logic       tail;

  // req_ready is a pure function of registered occupancy, so it never waits
  // on rsp_ready or req_valid in the same cycle.
  assign req_ready_w = (count_q < 2'd2);
  assign rsp_valid_w = (count_q != 2'd0);
  assign push        = bus.req_valid & req_ready_w;
  assign pop         = rsp_valid_w & bus.rsp_ready;

  // ---------------------------------------------------------------------------
  // Request decode: address split, legality, load extraction, store merge
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0]      idx;
  logic [1:0]            lane;
  logic [4:0]            sh;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [DATA_WIDTH-1:0] ld_data;
  logic [DATA_WIDTH-1:0] st_mask;
  logic                  acc_err;
  logic [DATA_WIDTH-1:0] rsp_rdata_new;
  logic [DATA_WIDTH-1:0] mem_wdata_d;
  logic                  mem_we_d;

  // Only the word-index bits of the address select storage; the rest are
  // deliberately ignored so accesses wrap.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.req_addr[ADDRESS_WIDTH-1:IDX_W+2];

  // NOTE: combinational blocks use blocking '=' and give every output a
  // default first, so no path leaves a signal unassigned and no latch appears.
  always_comb begin
    idx     = bus.req_addr[IDX_W+1:2];
    lane    = bus.req_addr[1:0];
    // For every legal access the lane offset in bits is simply lane*8; halves
    // and words are only legal at offsets where this is also correct.
    sh      = {lane, 3'b000};
    rd_word = mem_q[idx];
    ld_byte = 8'(rd_word >> sh);
    ld_half = 16'(rd_word >> sh);
    acc_err = 1'b0;
    ld_data = '0;
    st_mask = '0;

    if (bus.req_we) begin
      case (bus.req_funct3)
        F3_B: st_mask = BYTE_MASK << sh;
        F3_H: begin
          st_mask = HALF_MASK << sh;
          acc_err = lane[0];
        end
        F3_W: begin
          st_mask = '1;
          acc_err = |lane;
        end
        default: acc_err = 1'b1;
      endcase
    end else begin
      case (bus.req_funct3)
        F3_B:  ld_data = {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
        F3_BU: ld_data = {{(DATA_WIDTH-8){1'b0}}, ld_byte};
        F3_H: begin
          ld_data = {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
          acc_err = lane[0];
        end
        F3_HU: begin
          ld_data = {{(DATA_WIDTH-16){1'b0}}, ld_half};
          acc_err = lane[0];
        end
        F3_W: begin
          ld_data = rd_word;
          acc_err = |lane;
        end
        default: acc_err = 1'b1;
      endcase
    end

    // Read-modify-write: untouched byte lanes keep their old contents.
    mem_wdata_d   = (rd_word & ~st_mask) | ((bus.req_wdata << sh) & st_mask);
    mem_we_d      = push & bus.req_we & ~acc_err;
    rsp_rdata_new = (bus.req_we || acc_err) ? '0 : ld_data;
  end

  // NOTE: storage is deliberately left out of reset -- its contents must
  // survive rst. Reset only suppresses a write that would land on that edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // contents retained
    end else if (mem_we_d) begin
      mem_q[idx] <= mem_wdata_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Response FIFO (2 entries, in order)
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0]   ent_rdata_q [2];
  logic [DATA_WIDTH-1:0]   ent_rdata_d [2];
  logic [BITS_THREADS-1:0] ent_tid_q   [2];
  logic [BITS_THREADS-1:0] ent_tid_d   [2];
  logic                    ent_err_q   [2];
  logic                    ent_err_d   [2];

  always_comb begin
    ent_rdata_d = ent_rdata_q;
    ent_tid_d   = ent_tid_q;
    ent_err_d   = ent_err_q;
    // A push only happens with count 0 or 1, so the free slot is head+count
    // computed in one bit.
    tail        = head_q ^ count_q[0];

    if (push) begin
      ent_rdata_d[tail] = rsp_rdata_new;
      ent_tid_d[tail]   = bus.req_tid;
      ent_err_d[tail]   = acc_err;
    end

    head_d = pop ? ~head_q : head_q;

    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;   // idle, or accept and consume together
    endcase
  end

  // NOTE: sequential state uses non-blocking '<=' so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= 2'd0;
      head_q  <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        ent_rdata_q[i] <= '0;
        ent_tid_q[i]   <= '0;
        ent_err_q[i]   <= 1'b0;
      end
    end else begin
      count_q     <= count_d;
      head_q      <= head_d;
      ent_rdata_q <= ent_rdata_d;
      ent_tid_q   <= ent_tid_d;
      ent_err_q   <= ent_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: head entry, forced to zero when the FIFO is empty. Entries are
  // only rewritten on push into a free slot, so the head is stable under
  // back-pressure.
  // ---------------------------------------------------------------------------
  assign bus.req_ready = req_ready_w;
  assign bus.rsp_valid = rsp_valid_w;
  assign bus.rsp_rdata = rsp_valid_w ? ent_rdata_q[head_q] : '0;
  assign bus.rsp_tid   = rsp_valid_w ? ent_tid_q[head_q]   : '0;
  assign bus.rsp_err   = rsp_valid_w & ent_err_q[head_q];

endmodule : dmem_responder

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 32, data word width; ADDRESS_WIDTH, default 32, byte address width; NUM_THREADS, default 8, hardware thread count; BITS_THREADS, default $clog2(NUM_THREADS), thread-id width; DEPTH_WORDS, default 1024, storage depth in words (power of two).
REQ-002 Ports SHALL be: clk  in  1  sole clock, rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 req_valid  in  1  request present; req_ready  out  1  request accepted when both high at a rising edge.
REQ-005 req_we  in  1  store(1)/load(0); req_funct3  in  3  RV32I width/sign code; req_addr  in  ADDRESS_WIDTH  byte address; req_wdata  in  DATA_WIDTH  store data (low bytes used); req_tid  in  BITS_THREADS  issuing thread.
REQ-006 rsp_valid  out  1  response present; rsp_ready  in  1  response consumed when both high at a rising edge.
REQ-007 rsp_rdata  out  DATA_WIDTH  load result; rsp_tid  out  BITS_THREADS  thread of the response; rsp_err  out  1  request was rejected.

Function
REQ-008 Every accepted request SHALL produce exactly one response; responses SHALL leave in acceptance order.
REQ-009 Word index SHALL be req_addr[$clog2(DEPTH_WORDS)+1:2]; higher address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
REQ-010 Loads SHALL decode funct3 as: 000 LB (sign-extend), 001 LH (sign-extend), 010 LW, 100 LBU (zero-extend), 101 LHU (zero-extend), with byte/half selected by addr[1:0].
REQ-011 Stores SHALL decode funct3 as: 000 SB, 001 SH, 010 SW, writing only the addressed byte lanes from the low bits of req_wdata.
REQ-012 Error cases: half access with addr[0]=1, word access with addr[1:0]!=0, and load funct3 011/110/111 or store funct3 other than 000/001/010; these SHALL return rsp_err=1 and rsp_rdata=0, and SHALL NOT modify storage.
REQ-013 A successful store SHALL respond with rsp_err=0 and rsp_rdata=0; the write SHALL be visible to any request accepted at a later edge.
REQ-014 Accept-to-response latency SHALL be one cycle: a request accepted at edge N has its response at the FIFO head, with rsp_valid=1 after edge N if the FIFO was empty.
REQ-015 Responses SHALL be held in a 2-entry in-order FIFO; req_ready SHALL equal (count<2), SHALL be registered-state only, and SHALL NOT depend combinationally on rsp_ready or req_valid.
REQ-016 On a simultaneous accept and consume in one cycle, count SHALL stay unchanged and order SHALL be preserved.
REQ-017 With rsp_ready held high, one request per cycle SHALL be sustained indefinitely.
REQ-018 While rsp_valid=1 and rsp_ready=0, rsp_rdata, rsp_tid and rsp_err SHALL stay stable.

Reset
REQ-019 While rst=0: count=0, rsp_valid=0, rsp_rdata=0, rsp_tid=0, rsp_err=0, and req_ready=1 once rst is released.
REQ-020 Asserting rst mid-operation SHALL discard all queued responses immediately; storage contents are not reset, and an in-progress write at that edge SHALL NOT occur.

Verification
REQ-021 SW tid=3 addr 0x10 data 0xDEADBEEF, then LW tid=5 addr 0x10 -> rsp tid=3 err=0 rdata=0, then rsp tid=5 rdata=0xDEADBEEF.
REQ-022 After REQ-021, LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x10 -> 0xFFFFBEEF; LHU 0x12 -> 0x0000DEAD.
REQ-023 SH addr 0x11 and LW addr 0x12 -> both rsp_err=1, rdata=0; a following LW 0x10 still returns 0xDEADBEEF.
REQ-024 rsp_ready=0, issue 3 back-to-back loads -> req_ready drops after 2 accepts; raising rsp_ready drains both in order and the third is then accepted.
REQ-025 rsp_ready=1 with 8 loads on consecutive cycles, tids 0..7 -> 8 responses on consecutive cycles, tids 0..7 in order.
REQ-026 Assert rst with 2 responses queued -> rsp_valid=0 and req_ready=1 after release; SW at addr 0x10+DEPTH_WORDS*4 then LW 0x10 -> the stored value is returned (address wrap).
